// File: rtl/core_ctrl.sv
// core_ctrl: one start pulse sequences weight load, execute, activation stream and psum drain for every kernel position.
// Defining CORE_CTRL_PERF_EN adds the perf_cycles / perf_stall counters.
module core_ctrl #(
    parameter int col   = 8,
    parameter int KIJ   = 9,
    parameter int NPIX  = 36,
    parameter int W_AW  = 7,
    parameter int X_AW  = 10,
    parameter int P_AW  = 13,
    parameter int FLUSH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [3:0]      kij,
    output logic            w_cen,
    output logic            w_wen,
    output logic [W_AW-1:0] w_addr,
    output logic            x_cen,
    output logic            x_wen,
    output logic [X_AW-1:0] x_addr,
    output logic            psum_cen,
    output logic            psum_wen,
    output logic [P_AW-1:0] psum_addr,
    output logic            l0_wr,
    output logic            l0_rd,
    output logic [1:0]      inst_w,
    input  logic            l0_full,
    input  logic            l0_ready,
    output logic            ofifo_rd,
    input  logic            ofifo_valid
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_cycles,
    output logic [31:0]     perf_stall
`endif
);

    localparam int CW = 16;
    localparam logic [CW-1:0] COL_N    = CW'(col);
    localparam logic [CW-1:0] NPIX_N   = CW'(NPIX);
    localparam logic [CW-1:0] FLUSH_N  = CW'(FLUSH);
    localparam logic [3:0]    KIJ_LAST = 4'(KIJ - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_WEXEC, S_FLUSH, S_XSTREAM, S_DRAIN, S_DONE
    } state_t;

    state_t        state_r;
    logic [CW-1:0] iss_r, wr_r, pop_r, flush_r, psum_r;
    logic          can_issue_s, drain_s, last_psum_s;

    assign w_wen = 1'b1;
    assign x_wen = 1'b1;

    // A read issued this cycle is still in flight, so the next one waits a cycle: one word per two cycles.
    assign can_issue_s = w_cen & x_cen & ~l0_full;
    assign drain_s     = ((state_r == S_XSTREAM) || (state_r == S_DRAIN)) && ofifo_valid && (psum_r < NPIX_N);
    assign last_psum_s = drain_s && (psum_r == NPIX_N - 16'd1);

    // Sequencer FSM; every strobe and address is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            kij       <= 4'd0;
            w_cen     <= 1'b1;
            w_addr    <= '0;
            x_cen     <= 1'b1;
            x_addr    <= '0;
            psum_cen  <= 1'b1;
            psum_wen  <= 1'b1;
            psum_addr <= '0;
            l0_wr     <= 1'b0;
            l0_rd     <= 1'b0;
            inst_w    <= 2'b00;
            ofifo_rd  <= 1'b0;
            iss_r     <= 16'd0;
            wr_r      <= 16'd0;
            pop_r     <= 16'd0;
            flush_r   <= 16'd0;
            psum_r    <= 16'd0;
        end else begin
            w_cen    <= 1'b1;
            x_cen    <= 1'b1;
            psum_cen <= 1'b1;
            psum_wen <= 1'b1;
            l0_rd    <= 1'b0;
            inst_w   <= 2'b00;
            ofifo_rd <= 1'b0;
            done     <= 1'b0;
            // SRAM data lands one cycle after the read, so the L0 write follows every issue.
            l0_wr    <= ~(w_cen & x_cen);
            if (drain_s) begin
                ofifo_rd  <= 1'b1;
                psum_cen  <= 1'b0;
                psum_wen  <= 1'b0;
                psum_addr <= P_AW'(32'(kij) * 32'(NPIX) + 32'(psum_r));
                psum_r    <= psum_r + 16'd1;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r <= S_WLOAD;
                        busy    <= 1'b1;
                        kij     <= 4'd0;
                        iss_r   <= 16'd0;
                        wr_r    <= 16'd0;
                        pop_r   <= 16'd0;
                        psum_r  <= 16'd0;
                    end
                end
                S_WLOAD: begin
                    if (can_issue_s && (iss_r < COL_N)) begin
                        w_cen  <= 1'b0;
                        w_addr <= W_AW'(32'(kij) * 32'(col) + 32'(iss_r));
                        iss_r  <= iss_r + 16'd1;
                    end
                    if (l0_wr) begin
                        if (wr_r == COL_N - 16'd1) begin
                            wr_r    <= 16'd0;
                            state_r <= S_WEXEC;
                        end else begin
                            wr_r <= wr_r + 16'd1;
                        end
                    end
                end
                S_WEXEC: begin
                    if (l0_ready) begin
                        l0_rd  <= 1'b1;
                        inst_w <= 2'b01;
                        if (pop_r == COL_N - 16'd1) begin
                            pop_r   <= 16'd0;
                            flush_r <= 16'd0;
                            state_r <= S_FLUSH;
                        end else begin
                            pop_r <= pop_r + 16'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_r == FLUSH_N - 16'd1) begin
                        iss_r   <= 16'd0;
                        state_r <= S_XSTREAM;
                    end else begin
                        flush_r <= flush_r + 16'd1;
                    end
                end
                S_XSTREAM: begin
                    if (can_issue_s && (iss_r < NPIX_N)) begin
                        x_cen  <= 1'b0;
                        x_addr <= X_AW'(iss_r);
                        iss_r  <= iss_r + 16'd1;
                    end
                    if (l0_ready) begin
                        l0_rd  <= 1'b1;
                        inst_w <= 2'b10;
                        if (pop_r == NPIX_N - 16'd1) begin
                            pop_r   <= 16'd0;
                            state_r <= S_DRAIN;
                        end else begin
                            pop_r <= pop_r + 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_psum_s || (psum_r == NPIX_N)) begin
                        psum_r <= 16'd0;
                        if (kij == KIJ_LAST) begin
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            kij     <= kij + 4'd1;
                            iss_r   <= 16'd0;
                            wr_r    <= 16'd0;
                            pop_r   <= 16'd0;
                            state_r <= S_WLOAD;
                        end
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

`ifdef CORE_CTRL_PERF_EN
    // Run length and cycles where only a full L0 holds back an activation read.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= 32'd0;
            perf_stall  <= 32'd0;
        end else if ((state_r == S_IDLE) && start) begin
            perf_cycles <= 32'd0;
            perf_stall  <= 32'd0;
        end else begin
            if (busy) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if ((state_r == S_XSTREAM) && w_cen && x_cen && l0_full && (iss_r < NPIX_N)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized bench for core_ctrl: behavioural L0/OFIFO models plus address-sequence scoreboard derived from kernel/pixel arithmetic.
module tb_core_ctrl;
    localparam int COL = 8, KIJ = 2, NPIX = 4, W_AW = 7, X_AW = 10, P_AW = 13, FLUSH = 8;
    localparam int LIMIT = 3000;
    localparam logic [46:0] RST_VEC = {1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 7'd0, 1'b1, 1'b1, 10'd0,
                                       1'b1, 1'b1, 13'd0, 1'b0, 1'b0, 2'b00, 1'b0};

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, l0_full = 1'b0;
    logic l0_ready, ofifo_valid;
    logic busy, done, w_cen, w_wen, x_cen, x_wen, psum_cen, psum_wen, l0_wr, l0_rd, ofifo_rd;
    logic [3:0] kij;
    logic [1:0] inst_w;
    logic [W_AW-1:0] w_addr;
    logic [X_AW-1:0] x_addr;
    logic [P_AW-1:0] psum_addr;
`ifdef CORE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    core_ctrl #(.col(COL), .KIJ(KIJ), .NPIX(NPIX), .W_AW(W_AW), .X_AW(X_AW), .P_AW(P_AW), .FLUSH(FLUSH)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .kij(kij),
        .w_cen(w_cen), .w_wen(w_wen), .w_addr(w_addr), .x_cen(x_cen), .x_wen(x_wen), .x_addr(x_addr),
        .psum_cen(psum_cen), .psum_wen(psum_wen), .psum_addr(psum_addr),
        .l0_wr(l0_wr), .l0_rd(l0_rd), .inst_w(inst_w), .l0_full(l0_full), .l0_ready(l0_ready),
        .ofifo_rd(ofifo_rd), .ofifo_valid(ofifo_valid)
`ifdef CORE_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // L0 as an occupancy counter; OFIFO fills a programmable delay after each execute pop.
    int l0_cnt = 0, ofifo_occ = 0, ofifo_lat = 2;
    logic [7:0] push_pipe = 8'd0;
    logic gate = 1'b1, toggle_mode = 1'b0;
    assign l0_ready    = (l0_cnt > int'(l0_rd));
    assign ofifo_valid = gate && (ofifo_occ > int'(ofifo_rd));

    always @(posedge clk) begin
        if (reset) begin
            l0_cnt    <= 0;
            ofifo_occ <= 0;
            push_pipe <= 8'd0;
            gate      <= 1'b1;
        end else begin
            l0_cnt    <= l0_cnt + int'(l0_wr) - int'(l0_rd);
            push_pipe <= {push_pipe[6:0], (l0_rd && (inst_w == 2'b10))};
            ofifo_occ <= ofifo_occ + int'(push_pipe[ofifo_lat-1]) - int'(ofifo_rd);
            gate      <= toggle_mode ? ~gate : 1'b1;
        end
    end

    // Per-cycle protocol checks and event capture.
    logic mon_en = 1'b0, prev_issue = 1'b0, prev_reset = 1'b1, prev_full = 1'b0, prev_done = 1'b0;
    int w_q[$], x_q[$], p_q[$];
    int done_cnt = 0, kpop_cnt = 0, xpop_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("l0_wr_after_read", 64'(l0_wr), 64'(prev_issue & ~prev_reset));
            check_eq("psum_write_with_pop", 64'({psum_cen, psum_wen}), 64'({~ofifo_rd, ~ofifo_rd}));
            check_eq("inst_w_with_l0_rd", 64'(inst_w != 2'b00), 64'(l0_rd));
            if (!w_cen || !x_cen)
                check_eq("read_issue_rule", 64'({prev_full, prev_issue, w_wen, x_wen, (!w_cen && !x_cen)}), 64'(5'b00110));
            if (!w_cen) begin
                w_q.push_back(int'(w_addr));
                check_eq("kij_at_weight_read", 64'(kij), 64'(int'(w_addr) / COL));
            end
            if (!x_cen) x_q.push_back(int'(x_addr));
            if (!psum_cen) p_q.push_back(int'(psum_addr));
            if (ofifo_rd) check_eq("ofifo_pop_nonempty", 64'(ofifo_occ > 0), 64'(1));
            if (l0_rd) check_eq("l0_pop_nonempty", 64'(l0_cnt > 0), 64'(1));
            if (l0_rd && inst_w == 2'b01) kpop_cnt++;
            if (l0_rd && inst_w == 2'b10) xpop_cnt++;
            if (done) begin
                done_cnt++;
                check_eq("busy_during_done", 64'(busy), 64'(1));
            end
            if (prev_done) check_eq("busy_after_done", 64'(busy), 64'(0));
        end
        prev_issue = !w_cen || !x_cen;
        prev_reset = reset;
        prev_full  = l0_full;
        prev_done  = done;
    end

    task automatic clear_capture();
        w_q.delete(); x_q.delete(); p_q.delete();
        done_cnt = 0; kpop_cnt = 0; xpop_cnt = 0;
    endtask

    // mode 0: ideal, 1: l0_full held 10 cycles in XSTREAM, 2: ofifo_valid toggling, 3: start pulsed mid-run
    task automatic run_case(input string name, input int mode);
        int exp_w[$], exp_x[$], exp_p[$];
        int busy_cycles, cyc, full_left;
        bit injected;
        for (int k = 0; k < KIJ; k++) begin
            for (int j = 0; j < COL; j++) exp_w.push_back(k * COL + j);
            for (int j = 0; j < NPIX; j++) begin
                exp_x.push_back(j);
                exp_p.push_back(k * NPIX + j);
            end
        end
        ofifo_lat   = $urandom_range(1, 4);
        toggle_mode = (mode == 2);
        clear_capture();
        @(negedge clk);
        check_eq({name, ":idle_before_start"}, 64'({busy, done}), 64'(0));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check_eq({name, ":busy_rise"}, 64'(busy), 64'(1));
        busy_cycles = 1; cyc = 0; full_left = 0; injected = 1'b0;
        while (busy === 1'b1 && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (full_left > 0) begin
                full_left--;
                if (full_left == 0) l0_full = 1'b0;
            end else if (mode == 1 && !injected && x_q.size() == 2) begin
                l0_full = 1'b1; full_left = 10; injected = 1'b1;
            end
            if (mode == 3 && !injected && x_q.size() == 1) begin
                start = 1'b1; injected = 1'b1;
            end
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        l0_full = 1'b0; start = 1'b0; toggle_mode = 1'b0;
        check_eq({name, ":run_finished"}, 64'(busy), 64'(0));
        check_eq({name, ":done_count"}, 64'(done_cnt), 64'(1));
        check_eq({name, ":w_reads"}, 64'(w_q.size()), 64'(exp_w.size()));
        check_eq({name, ":x_reads"}, 64'(x_q.size()), 64'(exp_x.size()));
        check_eq({name, ":psum_writes"}, 64'(p_q.size()), 64'(exp_p.size()));
        check_eq({name, ":kernel_pops"}, 64'(kpop_cnt), 64'(KIJ * COL));
        check_eq({name, ":exec_pops"}, 64'(xpop_cnt), 64'(KIJ * NPIX));
        for (int i = 0; i < exp_w.size() && i < w_q.size(); i++)
            check_eq({name, ":w_addr"}, 64'(w_q[i]), 64'(exp_w[i]));
        for (int i = 0; i < exp_x.size() && i < x_q.size(); i++)
            check_eq({name, ":x_addr"}, 64'(x_q[i]), 64'(exp_x[i]));
        for (int i = 0; i < exp_p.size() && i < p_q.size(); i++)
            check_eq({name, ":psum_addr"}, 64'(p_q[i]), 64'(exp_p[i]));
`ifdef CORE_CTRL_PERF_EN
        check_eq({name, ":perf_cycles"}, 64'(perf_cycles), 64'(busy_cycles));
        if (mode == 1) check_eq({name, ":perf_stall_seen"}, 64'(perf_stall > 0), 64'(1));
        else check_eq({name, ":perf_stall"}, 64'(perf_stall), 64'(0));
`endif
    endtask

    task automatic reset_case();
        int cyc;
        clear_capture();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (kpop_cnt <= COL && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reset_mid:reached_wexec_kij1", 64'({kij, kpop_cnt > COL}), 64'({4'd1, 1'b1}));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_eq("reset_mid:outputs", 64'({busy, done, kij, w_cen, w_wen, w_addr, x_cen, x_wen, x_addr,
                                          psum_cen, psum_wen, psum_addr, l0_wr, l0_rd, inst_w, ofifo_rd}), 64'(RST_VEC));
        repeat (3) @(negedge clk);
        check_eq("reset_mid:stays_idle", 64'({busy, done, w_cen, x_cen}), 64'(4'b0011));
        check_eq("reset_mid:no_done", 64'(done_cnt), 64'(0));
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check_eq("reset:outputs", 64'({busy, done, kij, w_cen, w_wen, w_addr, x_cen, x_wen, x_addr,
                                       psum_cen, psum_wen, psum_addr, l0_wr, l0_rd, inst_w, ofifo_rd}), 64'(RST_VEC));
        run_case("ideal", 0);
        run_case("l0_full_window", 1);
        run_case("valid_toggle", 2);
        run_case("start_in_xstream", 3);
        reset_case();
        run_case("after_reset", 0);
        for (int r = 0; r < 3; r++) run_case("random", int'($urandom_range(0, 3)));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
